// File: rtl/dmem_pkg.sv
// Shared definitions for the byte-lane aware RV32 data memory: width codes,
// controller states and the legal response-latency range.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int LAT_MIN = 1;
    localparam int LAT_MAX = 4;

    typedef enum logic [1:0] {CLEAR, IDLE, WAIT} state_t;

    // Out-of-range latencies snap to the nearest legal value.
    function automatic int lat_clamp(input int lat);
        if (lat < LAT_MIN) return LAT_MIN;
        if (lat > LAT_MAX) return LAT_MAX;
        return lat;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane steering: store data replication plus lane mask, and
// load word shift with sign/zero extension.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  st_offset,
    input  logic [2:0]  st_funct3,
    input  logic [31:0] st_data,
    output logic [31:0] st_word,
    output logic [3:0]  st_mask,
    input  logic [1:0]  ld_offset,
    input  logic [2:0]  ld_funct3,
    input  logic [31:0] ld_word,
    output logic [31:0] ld_data
);

    logic [31:0] shifted;

    // Data is replicated into every lane so only the mask has to follow the offset.
    always_comb begin
        st_word = st_data;
        st_mask = 4'b1111;
        case (st_funct3)
            F3_B: begin
                st_word = {4{st_data[7:0]}};
                st_mask = 4'b0001 << st_offset;
            end
            F3_H: begin
                st_word = {2{st_data[15:0]}};
                st_mask = st_offset[1] ? 4'b1100 : 4'b0011;
            end
            default: ;
        endcase
    end

    always_comb begin
        shifted = ld_word >> {ld_offset, 3'b000};
        case (ld_funct3)
            F3_B:    ld_data = {{24{shifted[7]}}, shifted[7:0]};
            F3_H:    ld_data = {{16{shifted[15]}}, shifted[15:0]};
            F3_BU:   ld_data = {24'h000000, shifted[7:0]};
            F3_HU:   ld_data = {16'h0000, shifted[15:0]};
            default: ld_data = shifted;
        endcase
    end

endmodule

// File: rtl/data_mem_lsu.sv
// RV32 load/store data memory: one request per handshake, byte-lane merges,
// configurable response latency, error flagging and a post-reset clear sweep.
module data_mem_lsu
    import dmem_pkg::*;
#(
    parameter int DEPTH          = 1024,
    parameter int LAT            = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);

    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LAT_C = lat_clamp(LAT);

    state_t          state_reg, state_next;
    logic [AW-1:0]   clr_cnt_reg, clr_cnt_next;
    logic [1:0]      lat_cnt_reg, lat_cnt_next;
    logic            rsp_valid_reg, rsp_valid_next;

    logic            accept, req_err, f3_bad, st_we, clear_we;
    logic [AW-1:0]   word_idx, wr_idx;
    logic [31:0]     st_word, rd_word, ld_data;
    logic [3:0]      st_mask;

    logic [1:0]      ld_offset_reg;
    logic [2:0]      ld_funct3_reg;
    logic            err_reg, store_reg;

    assign req_ready = (state_reg == IDLE);
    assign busy      = (state_reg == CLEAR);
    assign accept    = req_valid & req_ready & reset;
    assign word_idx  = req_addr[AW+1:2];

    always_comb begin
        f3_bad = 1'b0;
        case (req_funct3)
            F3_B, F3_H, F3_W: f3_bad = 1'b0;
            F3_BU, F3_HU:     f3_bad = req_we;
            default:          f3_bad = 1'b1;
        endcase
        req_err = f3_bad
                | (((req_funct3 == F3_H) || (req_funct3 == F3_HU)) && req_addr[0])
                | ((req_funct3 == F3_W) && (req_addr[1:0] != 2'b00))
                | ({2'b00, req_addr[31:2]} >= 32'(DEPTH));
    end

    // Reset gates the sweep so a reset with clearing disabled never touches contents.
    assign clear_we = (state_reg == CLEAR) & reset;
    assign st_we    = accept & req_we & ~req_err;
    assign wr_idx   = clear_we ? clr_cnt_reg : word_idx;

    dmem_lane_align u_align (
        .st_offset (req_addr[1:0]),
        .st_funct3 (req_funct3),
        .st_data   (req_wdata),
        .st_word   (st_word),
        .st_mask   (st_mask),
        .ld_offset (ld_offset_reg),
        .ld_funct3 (ld_funct3_reg),
        .ld_word   (rd_word),
        .ld_data   (ld_data)
    );

    // One byte-wide RAM per lane gives a clean byte-enable write with registered read.
    genvar gi;
    for (gi = 0; gi < 4; gi++) begin : g_lane
        logic [7:0] mem [DEPTH];
        logic [7:0] rd_byte_reg;

        always_ff @(posedge clk) begin
            if (clear_we)
                mem[wr_idx] <= 8'h00;
            else if (st_we && st_mask[gi])
                mem[wr_idx] <= st_word[8*gi +: 8];
            if (accept)
                rd_byte_reg <= mem[word_idx];
        end

        assign rd_word[8*gi +: 8] = rd_byte_reg;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg     <= (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
            clr_cnt_reg   <= '0;
            lat_cnt_reg   <= '0;
            rsp_valid_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            clr_cnt_reg   <= clr_cnt_next;
            lat_cnt_reg   <= lat_cnt_next;
            rsp_valid_reg <= rsp_valid_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        clr_cnt_next   = clr_cnt_reg;
        lat_cnt_next   = lat_cnt_reg;
        rsp_valid_next = 1'b0;
        case (state_reg)
            CLEAR: begin
                if (clr_cnt_reg == AW'(DEPTH - 1)) begin
                    state_next   = IDLE;
                    clr_cnt_next = '0;
                end else begin
                    clr_cnt_next = clr_cnt_reg + 1'b1;
                end
            end
            IDLE: begin
                if (accept) begin
                    if (LAT_C == 1) begin
                        rsp_valid_next = 1'b1;
                    end else begin
                        state_next   = WAIT;
                        lat_cnt_next = '0;
                    end
                end
            end
            WAIT: begin
                if (lat_cnt_reg == 2'(LAT_C - 2)) begin
                    state_next     = IDLE;
                    rsp_valid_next = 1'b1;
                end else begin
                    lat_cnt_next = lat_cnt_reg + 1'b1;
                end
            end
            default: state_next = CLEAR;
        endcase
    end

    // Response attributes are latched at acceptance and held through WAIT.
    always_ff @(posedge clk) begin
        if (!reset) begin
            ld_offset_reg <= 2'b00;
            ld_funct3_reg <= 3'b000;
            err_reg       <= 1'b0;
            store_reg     <= 1'b0;
        end else if (accept) begin
            ld_offset_reg <= req_addr[1:0];
            ld_funct3_reg <= req_funct3;
            err_reg       <= req_err;
            store_reg     <= req_we;
        end
    end

    assign rsp_valid = rsp_valid_reg;
    assign rsp_err   = rsp_valid_reg & err_reg;
    assign rsp_rdata = (rsp_valid_reg & ~err_reg & ~store_reg) ? ld_data : 32'h0;

endmodule

// File: tb/tb_data_mem_lsu.sv
// Scoreboard bench: a LAT=1 / DEPTH=1024 instance and a LAT=3 / DEPTH=16 instance
// share clock and reset; responses are matched against queued expectations.
module tb_data_mem_lsu;

    localparam int DEPTH1 = 1024;
    localparam int DEPTH3 = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b0;

    logic        req_valid = 1'b0, req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic        req_ready, rsp_valid, rsp_err, busy;
    logic [31:0] rsp_rdata;

    logic        req_valid3 = 1'b0, req_we3 = 1'b0;
    logic [2:0]  req_funct33 = 3'b000;
    logic [31:0] req_addr3 = '0, req_wdata3 = '0;
    logic        req_ready3, rsp_valid3, rsp_err3, busy3;
    logic [31:0] rsp_rdata3;

    int n_checks = 0;
    int n_fail   = 0;

    logic [32:0] q1[$];
    logic [32:0] q3[$];

    always #5 clk = ~clk;

    data_mem_lsu #(.DEPTH(DEPTH1), .LAT(1), .CLEAR_ON_RESET(1)) u_dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy)
    );

    data_mem_lsu #(.DEPTH(DEPTH3), .LAT(3), .CLEAR_ON_RESET(1)) u_dut3 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid3), .req_ready(req_ready3), .req_we(req_we3),
        .req_funct3(req_funct33), .req_addr(req_addr3), .req_wdata(req_wdata3),
        .rsp_valid(rsp_valid3), .rsp_rdata(rsp_rdata3), .rsp_err(rsp_err3), .busy(busy3)
    );

    // Scoreboard pops: one line per completed transaction.
    always @(negedge clk) begin
        logic [32:0] e;
        if (rsp_valid === 1'b1) begin
            n_checks++;
            if (q1.size() == 0) begin
                n_fail++;
                $display("FAIL rsp1_unexpected: got err=%b rdata=%h, required no response", rsp_err, rsp_rdata);
            end else begin
                e = q1.pop_front();
                if ({rsp_err, rsp_rdata} !== e) begin
                    n_fail++;
                    $display("FAIL rsp1: got err=%b rdata=%h, required err=%b rdata=%h", rsp_err, rsp_rdata, e[32], e[31:0]);
                end else
                    $display("rsp1 ok err=%b rdata=%h", rsp_err, rsp_rdata);
            end
        end
        if (rsp_valid3 === 1'b1) begin
            n_checks++;
            if (q3.size() == 0) begin
                n_fail++;
                $display("FAIL rsp3_unexpected: got err=%b rdata=%h, required no response", rsp_err3, rsp_rdata3);
            end else begin
                e = q3.pop_front();
                if ({rsp_err3, rsp_rdata3} !== e) begin
                    n_fail++;
                    $display("FAIL rsp3: got err=%b rdata=%h, required err=%b rdata=%h", rsp_err3, rsp_rdata3, e[32], e[31:0]);
                end else
                    $display("rsp3 ok err=%b rdata=%h", rsp_err3, rsp_rdata3);
            end
        end
    end

    task automatic send(input int which, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input logic exp_err);
        int t = 0;
        if (which == 0) begin
            req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        end else begin
            req_valid3 = 1'b1; req_we3 = we; req_funct33 = f3; req_addr3 = addr; req_wdata3 = wdata;
        end
        forever begin
            @(negedge clk);
            if ((which == 0) ? req_ready : req_ready3) break;
            t++;
            if (t > 200) begin
                n_checks++;
                n_fail++;
                $display("FAIL handshake_timeout: dut%0d req_ready stayed low, required high", which);
                req_valid = 1'b0;
                req_valid3 = 1'b0;
                return;
            end
        end
        if (which == 0) q1.push_back({exp_err, exp_rdata});
        else            q3.push_back({exp_err, exp_rdata});
        @(posedge clk);
        #1;
        req_valid  = 1'b0;
        req_valid3 = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while ((q1.size() != 0 || q3.size() != 0) && t < 100) begin
            @(negedge clk);
            t++;
        end
        n_checks++;
        if (q1.size() != 0 || q3.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d/%0d pending responses, required 0", q1.size(), q3.size());
            q1.delete();
            q3.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int cnt = 0;
        reset = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if ({busy, req_ready, rsp_valid, rsp_err} !== 4'b1000) begin
            n_fail++;
            $display("FAIL reset_flags: got busy/ready/valid/err=%b, required 1000", {busy, req_ready, rsp_valid, rsp_err});
        end
        n_checks++;
        if (rsp_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_rdata: got %h, required 00000000", rsp_rdata);
        end
        reset = 1'b1;
        for (int c = 0; c < 2 * DEPTH1; c++) begin
            @(negedge clk);
            if (busy !== 1'b1) break;
            cnt++;
            n_checks++;
            if (req_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL ready_in_clear: got %b at cycle %0d, required 0", req_ready, c);
            end
        end
        n_checks++;
        if (cnt != DEPTH1) begin
            n_fail++;
            $display("FAIL clear_cycles: got %0d, required %0d", cnt, DEPTH1);
        end
        n_checks++;
        if ({req_ready, busy3, req_ready3} !== 3'b101) begin
            n_fail++;
            $display("FAIL post_clear: got ready/busy3/ready3=%b, required 101", {req_ready, busy3, req_ready3});
        end
        $display("reset: clear took %0d cycles", cnt);
        @(posedge clk);
        #1;
        send(0, 1'b0, 3'b010, 32'h10, 32'h0, 32'h0, 1'b0);
        drain();
    endtask

    task automatic test_load_extend();
        send(0, 1'b1, 3'b010, 32'h8, 32'hDEADBEEF, 32'h0, 1'b0);
        send(0, 1'b0, 3'b000, 32'h8, 32'h0, 32'hFFFFFFEF, 1'b0);
        send(0, 1'b0, 3'b100, 32'hB, 32'h0, 32'h000000DE, 1'b0);
        send(0, 1'b0, 3'b001, 32'hA, 32'h0, 32'hFFFFDEAD, 1'b0);
        send(0, 1'b0, 3'b101, 32'h8, 32'h0, 32'h0000BEEF, 1'b0);
        drain();
    endtask

    task automatic test_store_merge();
        send(0, 1'b1, 3'b000, 32'h9, 32'h00000012, 32'h0, 1'b0);
        send(0, 1'b0, 3'b010, 32'h8, 32'h0, 32'hDEAD12EF, 1'b0);
        send(0, 1'b1, 3'b001, 32'hA, 32'h00005566, 32'h0, 1'b0);
        send(0, 1'b0, 3'b010, 32'h8, 32'h0, 32'h556612EF, 1'b0);
        drain();
    endtask

    task automatic test_errors();
        send(0, 1'b0, 3'b010, 32'h6, 32'h0, 32'h0, 1'b1);
        send(0, 1'b1, 3'b001, 32'h3, 32'hFFFF, 32'h0, 1'b1);
        send(0, 1'b0, 3'b011, 32'h0, 32'h0, 32'h0, 1'b1);
        send(0, 1'b0, 3'b010, 32'(4 * DEPTH1), 32'h0, 32'h0, 1'b1);
        send(0, 1'b1, 3'b100, 32'h8, 32'hFFFFFFFF, 32'h0, 1'b1);
        send(0, 1'b1, 3'b010, 32'h9, 32'hFFFFFFFF, 32'h0, 1'b1);
        send(0, 1'b0, 3'b010, 32'h8, 32'h0, 32'h556612EF, 1'b0);
        drain();
    endtask

    task automatic test_latency();
        send(1, 1'b1, 3'b010, 32'h8, 32'hA5A50001, 32'h0, 1'b0);
        drain();
        send(1, 1'b0, 3'b000, 32'hB, 32'h0, 32'hFFFFFFA5, 1'b0);
        n_checks++;
        if ({req_ready3, rsp_valid3, rsp_err3} !== 3'b000 || rsp_rdata3 !== 32'h0) begin
            n_fail++;
            $display("FAIL lat_t0: got ready/valid/err=%b rdata=%h, required 000 00000000", {req_ready3, rsp_valid3, rsp_err3}, rsp_rdata3);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if ({req_ready3, rsp_valid3} !== 2'b00) begin
            n_fail++;
            $display("FAIL lat_t1: got ready/valid=%b, required 00", {req_ready3, rsp_valid3});
        end
        @(posedge clk);
        #1;
        n_checks++;
        if ({req_ready3, rsp_valid3} !== 2'b11) begin
            n_fail++;
            $display("FAIL lat_t2: got ready/valid=%b, required 11", {req_ready3, rsp_valid3});
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (rsp_valid3 !== 1'b0 || rsp_rdata3 !== 32'h0) begin
            n_fail++;
            $display("FAIL lat_t3: got valid=%b rdata=%h, required 0 00000000", rsp_valid3, rsp_rdata3);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        int first = -1, last = -1, cnt = 0;
        fork
            begin
                send(0, 1'b0, 3'b010, 32'h8, 32'h0, 32'h556612EF, 1'b0);
                send(0, 1'b0, 3'b000, 32'h8, 32'h0, 32'hFFFFFFEF, 1'b0);
                send(0, 1'b0, 3'b101, 32'hA, 32'h0, 32'h00005566, 1'b0);
                send(0, 1'b0, 3'b100, 32'h9, 32'h0, 32'h00000012, 1'b0);
            end
            begin
                for (int c = 0; c < 20; c++) begin
                    @(negedge clk);
                    if (rsp_valid === 1'b1) begin
                        if (first < 0) first = c;
                        last = c;
                        cnt++;
                    end
                end
            end
        join
        n_checks++;
        if (cnt != 4 || (last - first) != 3) begin
            n_fail++;
            $display("FAIL back_to_back: got %0d pulses spanning %0d cycles, required 4 spanning 3", cnt, last - first);
        end
        drain();
    endtask

    task automatic test_reset_in_wait();
        int cnt = 0;
        int t = 0;
        send(1, 1'b0, 3'b010, 32'h8, 32'h0, 32'hA5A50001, 1'b0);
        reset = 1'b0;
        q3.delete();
        @(posedge clk);
        #1;
        n_checks++;
        if ({busy3, req_ready3, rsp_valid3, busy} !== 4'b1001) begin
            n_fail++;
            $display("FAIL reset_wait: got busy3/ready3/valid3/busy=%b, required 1001", {busy3, req_ready3, rsp_valid3, busy});
        end
        reset = 1'b1;
        for (int c = 0; c < 4 * DEPTH3; c++) begin
            @(negedge clk);
            n_checks++;
            if (rsp_valid3 !== 1'b0) begin
                n_fail++;
                $display("FAIL dropped_rsp: got rsp_valid3=%b, required 0", rsp_valid3);
            end
            if (busy3 !== 1'b1) break;
            cnt++;
        end
        n_checks++;
        if (cnt != DEPTH3) begin
            n_fail++;
            $display("FAIL clear3_cycles: got %0d, required %0d", cnt, DEPTH3);
        end
        while (busy === 1'b1 && t < 2 * DEPTH1) begin
            @(negedge clk);
            t++;
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL clear1_timeout: got busy=%b, required 0", busy);
        end
        @(posedge clk);
        #1;
        send(1, 1'b0, 3'b010, 32'h8, 32'h0, 32'h0, 1'b0);
        send(0, 1'b0, 3'b010, 32'h8, 32'h0, 32'h0, 1'b0);
        drain();
    endtask

    initial begin
        test_reset();
        test_load_extend();
        test_store_merge();
        test_errors();
        test_latency();
        test_back_to_back();
        test_reset_in_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
